md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with an architectural HI/LO register pair.
- Sits in stage E beside the ALU. It takes forwarded rs/rt operands and exposes busy/start to the stage-D stall logic. HI/LO are carried down the pipe for mfhi/mflo writeback.
- Compared with the previous fixed-function unit, it adds:
  - configurable data width and latencies;
  - a flush input that aborts an in-flight operation;
  - defined divide-by-zero results;
  - optional multiply-accumulate operations.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits.
- MULT_CYCLES, 5: busy cycles for multiply-class ops; legal range >=1.
- DIV_CYCLES, 10: busy cycles for divide-class ops; legal range >=1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- valid_i  in  1  op_i/rs_i/rt_i are valid this cycle.
- op_i  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 reserved, treated as NOP.
- rs_i  in  WIDTH  first operand (forwarded).
- rt_i  in  WIDTH  second operand (forwarded).
- flush_i  in  1  abort the in-flight operation; blocks acceptance this cycle.
- start_o  out  1  combinational: valid_i && op_i is a multi-cycle op && !busy_o && !flush_i.
- busy_o  out  1  registered: a multi-cycle op is in progress.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

Behaviour:
- Clocking and reset:
  - Single clock domain clk, synchronous active-high reset.
  - Reset overrides everything, including a mid-operation op: busy_o=0, counter=0, HI=0, LO=0, pending registers=0. start_o follows its equation.
- States: IDLE (busy_o=0), BUSY (busy_o=1). A down-counter of ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)) bits tracks the remaining cycles.
- Acceptance:
  - An op is accepted at a rising edge when valid_i=1, busy_o=0 and flush_i=0.
  - valid_i while busy_o=1 is ignored; stage D is stalled by busy_o/start_o, so the op is re-presented.
- MTHI/MTLO:
  - Single-cycle: HI<=rs_i (or LO<=rs_i) at the accept edge.
  - No BUSY entry; start_o=0.
- Multi-cycle ops:
  - At the accept edge the full result is computed into pend_hi/pend_lo, the counter is loaded with the latency, and the state goes to BUSY.
  - Each BUSY edge decrements the counter. At the edge where counter==1: HI<=pend_hi, LO<=pend_lo, state goes to IDLE.
  - busy_o is therefore high for exactly N cycles, and the new HI/LO are visible in the first cycle with busy_o=0.
  - A new op may be accepted in that same cycle (back-to-back).
- Arithmetic:
  - MULT/MULTU: {HI,LO} = signed/unsigned rs*rt (2*WIDTH bits).
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Signed overflow (DIV of most-negative/-1): LO = most-negative, HI = 0.
  - Divide by zero (rt==0): LO = all ones, HI = rs; latency unchanged.
- flush_i:
  - In BUSY: the next state is IDLE, HI/LO are unchanged, pend_* are discarded, and busy_o=0 on the next cycle.
  - In IDLE: no op is accepted that cycle, including MTHI/MTLO.
  - flush_i on the counter==1 edge: flush wins and HI/LO are not committed.
- HI/LO are never written except by an accepted MTHI/MTLO, a completing op, or reset.

Optional Feature:
- Macro MD_UNIT_MACC_EN.
- Defined:
  - MADD/MADDU: {HI,LO} += signed/unsigned rs*rt.
  - MSUB/MSUBU: {HI,LO} -= signed/unsigned rs*rt.
  - All four use MULT_CYCLES latency, are computed modulo 2^(2*WIDTH), and the accumulator is sampled from HI/LO at the accept edge.
- Undefined: op codes 7-10 behave as NOP (no start_o, no busy_o, HI/LO unchanged), and the accumulate datapath is not synthesised.

Test Plan:
- MULT rs=32'hFFFFFFFD (-3), rt=5 -> busy_o high exactly 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; start_o=1 only in the accept cycle.
- DIV rs=-7, rt=2 -> after 10 busy cycles LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU rs=7, rt=2 -> LO=3, HI=1.
- DIVU rs=32'h12345678, rt=0 -> LO=32'hFFFFFFFF, HI=32'h12345678. DIV rs=32'h80000000, rt=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- MTHI rs=32'hA5A5A5A5 with busy_o=0 -> HI=A5A5A5A5 next cycle, busy_o stays 0. Same MTHI while busy_o=1 -> ignored, HI unchanged.
- HI=1, LO=2, then MULTU 3*4 with flush_i pulsed on the 3rd busy cycle -> busy_o=0 next cycle, HI=1, LO=2 retained. Repeat with reset instead of flush -> HI=LO=0, busy_o=0.
- With MD_UNIT_MACC_EN defined: HI=0, LO=32'hFFFFFFFF, MADDU 1*1 -> HI=1, LO=0 after 5 cycles. Without the macro: same stimulus leaves HI=0, LO=32'hFFFFFFFF, busy_o never asserts.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for pipeline stage E.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) enabled by defining MD_UNIT_MACC_EN.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic             flush_i,
    output logic             start_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_UNIT_MACC_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, next_state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi, lo, pend_hi, pend_lo;
    logic               is_mult, is_div, is_macc, is_multi, is_move;
    logic [CW-1:0]      load_count;
    logic [2*WIDTH-1:0] result;

    logic signed [2*WIDTH-1:0] rs_sx, rt_sx;
    logic [2*WIDTH-1:0]        prod_s, prod_u;
    logic                      rs_neg, rt_neg, div_ovf;
    logic [WIDTH-1:0]          rs_mag, rt_mag, sdivisor, udivisor;
    logic [WIDTH-1:0]          sq_mag, sr_mag, sdiv_quo, sdiv_rem;

    assign rs_sx  = {{WIDTH{rs_i[WIDTH-1]}}, rs_i};
    assign rt_sx  = {{WIDTH{rt_i[WIDTH-1]}}, rt_i};
    assign prod_s = rs_sx * rt_sx;
    assign prod_u = {{WIDTH{1'b0}}, rs_i} * {{WIDTH{1'b0}}, rt_i};

    // Signed divide on magnitudes: quotient truncates toward zero, remainder takes the dividend's sign.
    assign rs_neg   = rs_i[WIDTH-1];
    assign rt_neg   = rt_i[WIDTH-1];
    assign rs_mag   = rs_neg ? -rs_i : rs_i;
    assign rt_mag   = rt_neg ? -rt_i : rt_i;
    assign sdivisor = (rt_mag == '0) ? WIDTH'(1) : rt_mag;
    assign udivisor = (rt_i == '0) ? WIDTH'(1) : rt_i;
    assign sq_mag   = rs_mag / sdivisor;
    assign sr_mag   = rs_mag % sdivisor;
    assign sdiv_quo = (rs_neg ^ rt_neg) ? -sq_mag : sq_mag;
    assign sdiv_rem = rs_neg ? -sr_mag : sr_mag;
    assign div_ovf  = (rs_i == MIN_VAL) && (rt_i == '1);

    always_comb begin
        is_mult = (op_i == OP_MULT) || (op_i == OP_MULTU);
        is_div  = (op_i == OP_DIV) || (op_i == OP_DIVU);
`ifdef MD_UNIT_MACC_EN
        is_macc = (op_i == OP_MADD) || (op_i == OP_MADDU) || (op_i == OP_MSUB) || (op_i == OP_MSUBU);
`else
        is_macc = 1'b0;
`endif
        is_multi   = is_mult || is_div || is_macc;
        is_move    = (op_i == OP_MTHI) || (op_i == OP_MTLO);
        load_count = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end

    always_comb begin
        result = '0;
        case (op_i)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV: begin
                if (rt_i == '0)
                    result = {rs_i, {WIDTH{1'b1}}};
                else if (div_ovf)
                    result = {{WIDTH{1'b0}}, MIN_VAL};
                else
                    result = {sdiv_rem, sdiv_quo};
            end
            OP_DIVU: begin
                if (rt_i == '0)
                    result = {rs_i, {WIDTH{1'b1}}};
                else
                    result = {rs_i % udivisor, rs_i / udivisor};
            end
`ifdef MD_UNIT_MACC_EN
            OP_MADD:  result = {hi, lo} + prod_s;
            OP_MADDU: result = {hi, lo} + prod_u;
            OP_MSUB:  result = {hi, lo} - prod_s;
            OP_MSUBU: result = {hi, lo} - prod_u;
`endif
            default:  result = '0;
        endcase
    end

    assign start_o = valid_i && is_multi && !busy_o && !flush_i;
    assign busy_o  = (state == BUSY);
    assign hi_o    = hi;
    assign lo_o    = lo;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_o) next_state = BUSY;
            BUSY: if (flush_i || count == CW'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Flush in BUSY drops the pending result; HI/LO commit only on an unflushed final edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                if (start_o) begin
                    {pend_hi, pend_lo} <= result;
                    count              <= load_count;
                end else if (valid_i && is_move && !flush_i) begin
                    if (op_i == OP_MTHI)
                        hi <= rs_i;
                    else
                        lo <= rs_i;
                end
            end else if (flush_i) begin
                count <= '0;
            end else begin
                count <= count - CW'(1);
                if (count == CW'(1)) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: mult/div results, latencies, flush, reset and MACC ops.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        flush;
    logic        start;
    logic        busy;
    logic [31:0] hi, lo;

    int tests = 0;
    int failed = 0;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .valid_i(valid), .op_i(op), .rs_i(rs), .rt_i(rt),
        .flush_i(flush), .start_o(start), .busy_o(busy), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        #1;
    endtask

    task automatic idle_inputs();
        valid = 1'b0;
        op    = 4'd0;
        rs    = '0;
        rt    = '0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        drive(4'd5, h, 32'd0);
        step();
        drive(4'd6, l, 32'd0);
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (hi !== 32'd0 || lo !== 32'd0) begin failed++; $display("[TB] FAIL reset_hilo: got %h/%h expected 0/0", hi, lo); end
        tests++; if (start !== 1'b0) begin failed++; $display("[TB] FAIL reset_start: got %b expected 0", start); end
    endtask

    task automatic test_mult();
        int n;
        drive(4'd1, 32'hFFFFFFFD, 32'd5);
        tests++; if (start !== 1'b1) begin failed++; $display("[TB] FAIL mult_start_accept: got %b expected 1", start); end
        step();
        // a second op presented during busy must be ignored and must not raise start
        drive(4'd1, 32'd1, 32'd1);
        tests++; if (start !== 1'b0) begin failed++; $display("[TB] FAIL mult_start_busy: got %b expected 0", start); end
        step();
        idle_inputs();
        wait_idle(n);
        n = n + 1;
        tests++; if (n !== 5) begin failed++; $display("[TB] FAIL mult_latency: got %0d expected 5", n); end
        tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin failed++; $display("[TB] FAIL mult_result: got %h/%h expected ffffffff/fffffff1", hi, lo); end
        step();
        tests++; if (busy !== 1'b0 || lo !== 32'hFFFFFFF1) begin failed++; $display("[TB] FAIL mult_ignored_op: busy %b lo %h expected 0 fffffff1", busy, lo); end
    endtask

    task automatic test_div();
        int n;
        drive(4'd3, 32'hFFFFFFF9, 32'd2);
        step();
        idle_inputs();
        wait_idle(n);
        tests++; if (n !== 10) begin failed++; $display("[TB] FAIL div_latency: got %0d expected 10", n); end
        tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin failed++; $display("[TB] FAIL div_signed: got %h/%h expected ffffffff/fffffffd", hi, lo); end
        drive(4'd4, 32'd7, 32'd2);
        step();
        idle_inputs();
        wait_idle(n);
        tests++; if (hi !== 32'd1 || lo !== 32'd3) begin failed++; $display("[TB] FAIL divu: got %h/%h expected 1/3", hi, lo); end
    endtask

    task automatic test_div_special();
        int n;
        drive(4'd4, 32'h12345678, 32'd0);
        step();
        idle_inputs();
        wait_idle(n);
        tests++; if (n !== 10) begin failed++; $display("[TB] FAIL div0_latency: got %0d expected 10", n); end
        tests++; if (hi !== 32'h12345678 || lo !== 32'hFFFFFFFF) begin failed++; $display("[TB] FAIL divu_by_zero: got %h/%h expected 12345678/ffffffff", hi, lo); end
        drive(4'd3, 32'h80000000, 32'hFFFFFFFF);
        step();
        idle_inputs();
        wait_idle(n);
        tests++; if (hi !== 32'd0 || lo !== 32'h80000000) begin failed++; $display("[TB] FAIL div_overflow: got %h/%h expected 0/80000000", hi, lo); end
        drive(4'd3, 32'hFFFFFFF9, 32'd0);
        step();
        idle_inputs();
        wait_idle(n);
        tests++; if (hi !== 32'hFFFFFFF9 || lo !== 32'hFFFFFFFF) begin failed++; $display("[TB] FAIL div_by_zero: got %h/%h expected fffffff9/ffffffff", hi, lo); end
    endtask

    task automatic test_mthi();
        int n;
        drive(4'd5, 32'hA5A5A5A5, 32'd0);
        tests++; if (start !== 1'b0) begin failed++; $display("[TB] FAIL mthi_start: got %b expected 0", start); end
        step();
        idle_inputs();
        tests++; if (hi !== 32'hA5A5A5A5 || busy !== 1'b0) begin failed++; $display("[TB] FAIL mthi_write: hi %h busy %b expected a5a5a5a5 0", hi, busy); end
        drive(4'd6, 32'h5A5A0001, 32'd0);
        step();
        idle_inputs();
        tests++; if (lo !== 32'h5A5A0001 || hi !== 32'hA5A5A5A5) begin failed++; $display("[TB] FAIL mtlo_write: got %h/%h expected a5a5a5a5/5a5a0001", hi, lo); end
        drive(4'd2, 32'd2, 32'd3);
        step();
        drive(4'd5, 32'h12345678, 32'd0);
        step();
        idle_inputs();
        tests++; if (hi !== 32'hA5A5A5A5) begin failed++; $display("[TB] FAIL mthi_busy_ignored: got %h expected a5a5a5a5", hi); end
        wait_idle(n);
        tests++; if (hi !== 32'd0 || lo !== 32'd6) begin failed++; $display("[TB] FAIL multu_after_mthi: got %h/%h expected 0/6", hi, lo); end
    endtask

    task automatic test_flush();
        int n;
        set_hilo(32'd1, 32'd2);
        drive(4'd2, 32'd3, 32'd4);
        step();
        idle_inputs();
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
        step();
        step();
        step();
        tests++; if (hi !== 32'd1 || lo !== 32'd2) begin failed++; $display("[TB] FAIL flush_hilo: got %h/%h expected 1/2", hi, lo); end
        // flush on the final busy edge must still prevent the commit
        drive(4'd2, 32'd3, 32'd4);
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
        tests++; if (busy !== 1'b1) begin failed++; $display("[TB] FAIL flush_last_pre: got %b expected 1", busy); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if (busy !== 1'b0 || hi !== 32'd1 || lo !== 32'd2) begin failed++; $display("[TB] FAIL flush_last_edge: busy %b hilo %h/%h expected 0 1/2", busy, hi, lo); end
        flush = 1'b1;
        drive(4'd5, 32'h77, 32'd0);
        step();
        drive(4'd1, 32'd3, 32'd3);
        tests++; if (start !== 1'b0) begin failed++; $display("[TB] FAIL flush_idle_start: got %b expected 0", start); end
        step();
        flush = 1'b0;
        idle_inputs();
        tests++; if (busy !== 1'b0 || hi !== 32'd1) begin failed++; $display("[TB] FAIL flush_idle_block: busy %b hi %h expected 0 1", busy, hi); end
        wait_idle(n);
    endtask

    task automatic test_reset_mid();
        set_hilo(32'd1, 32'd2);
        drive(4'd2, 32'd3, 32'd4);
        step();
        idle_inputs();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin failed++; $display("[TB] FAIL reset_mid: busy %b hilo %h/%h expected 0 0/0", busy, hi, lo); end
        for (int i = 0; i < 6; i++) step();
        tests++; if (hi !== 32'd0 || lo !== 32'd0) begin failed++; $display("[TB] FAIL reset_mid_later: got %h/%h expected 0/0", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int n;
        drive(4'd2, 32'd2, 32'd3);
        step();
        idle_inputs();
        wait_idle(n);
        drive(4'd4, 32'd100, 32'd7);
        tests++; if (start !== 1'b1 || lo !== 32'd6) begin failed++; $display("[TB] FAIL b2b_accept: start %b lo %h expected 1 6", start, lo); end
        step();
        idle_inputs();
        wait_idle(n);
        tests++; if (n !== 10 || hi !== 32'd2 || lo !== 32'd14) begin failed++; $display("[TB] FAIL b2b_divu: cycles %0d hilo %h/%h expected 10 2/e", n, hi, lo); end
    endtask

    task automatic test_macc();
        int n;
        set_hilo(32'd0, 32'hFFFFFFFF);
        drive(4'd8, 32'd1, 32'd1);
`ifdef MD_UNIT_MACC_EN
        tests++; if (start !== 1'b1) begin failed++; $display("[TB] FAIL maddu_start: got %b expected 1", start); end
        step();
        idle_inputs();
        wait_idle(n);
        tests++; if (n !== 5) begin failed++; $display("[TB] FAIL maddu_latency: got %0d expected 5", n); end
        tests++; if (hi !== 32'd1 || lo !== 32'd0) begin failed++; $display("[TB] FAIL maddu_result: got %h/%h expected 1/0", hi, lo); end
        drive(4'd9, 32'hFFFFFFFF, 32'd1);
        step();
        idle_inputs();
        wait_idle(n);
        tests++; if (hi !== 32'd1 || lo !== 32'd1) begin failed++; $display("[TB] FAIL msub_result: got %h/%h expected 1/1", hi, lo); end
`else
        tests++; if (start !== 1'b0) begin failed++; $display("[TB] FAIL maddu_start: got %b expected 0", start); end
        step();
        idle_inputs();
        wait_idle(n);
        tests++; if (n !== 0) begin failed++; $display("[TB] FAIL maddu_busy: got %0d busy cycles expected 0", n); end
        tests++; if (hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin failed++; $display("[TB] FAIL maddu_nop: got %h/%h expected 0/ffffffff", hi, lo); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        idle_inputs();
        test_reset();
        test_mult();
        test_div();
        test_div_special();
        test_mthi();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_macc();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
